// File: rtl/spi_byte_capture_if.sv
// Purpose : bundles the raw SPI bus, the downstream done level and the captured-word outputs.
// Latency : n/a (signal bundle only).
// Backpressure: done_sig is the downstream acknowledge; busy tells the producer side a word is pending.
// Ports   : master = bench/SPI side (drives ss_n, sclk, mosi, miso, done_sig);
//           slave  = capture block (drives real_mosi_data, real_miso_data, eval, busy, frame_active, overrun_err).
interface spi_byte_capture_if #(
    parameter int DATA_SIZE = 8
) ();
    logic                 ss_n;
    logic                 sclk;
    logic                 mosi;
    logic                 miso;
    logic                 done_sig;
    logic [DATA_SIZE-1:0] real_mosi_data;
    logic [DATA_SIZE-1:0] real_miso_data;
    logic                 eval;
    logic                 busy;
    logic                 frame_active;
    logic                 overrun_err;

    modport master (
        output ss_n, sclk, mosi, miso, done_sig,
        input  real_mosi_data, real_miso_data, eval, busy, frame_active, overrun_err
    );

    modport slave (
        input  ss_n, sclk, mosi, miso, done_sig,
        output real_mosi_data, real_miso_data, eval, busy, frame_active, overrun_err
    );
endinterface

// File: rtl/spi_byte_capture.sv
// Purpose : samples a raw mode-0 SPI bus in sys_clk, deserialises MOSI/MISO words MSB first, pulses eval per word pair.
// Latency : eval + data visible after sys_clk edge SYNC_STAGES+1, counting from the first edge that samples the SCLK rise.
// Backpressure: after eval, waits for done_sig low then high; words completing meanwhile are dropped and set overrun_err.
// Ports   : sys_clk, rst (async, active high); bus.slave carries ss_n/sclk/mosi/miso/done_sig in and
//           real_mosi_data/real_miso_data/eval/busy/frame_active/overrun_err out.
module spi_byte_capture #(
    parameter int DATA_SIZE   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               sys_clk,
    input  logic               rst,
    spi_byte_capture_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        HS_READY    = 2'b00,
        HS_ACK_LOW  = 2'b01,
        HS_ACK_HIGH = 2'b10
    } hs_state_t;

    // Synchroniser chains; the last stage of each is the usable sys_clk-domain copy.
    logic [SYNC_STAGES-1:0] ss_n_ff;
    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] mosi_ff;
    logic [SYNC_STAGES-1:0] miso_ff;
    logic                   sclk_prev;
    logic                   ss_n_prev;

    logic ss_n_sync;
    logic sclk_sync;
    logic mosi_sync;
    logic miso_sync;

    assign ss_n_sync = ss_n_ff[SYNC_STAGES-1];
    assign sclk_sync = sclk_ff[SYNC_STAGES-1];
    assign mosi_sync = mosi_ff[SYNC_STAGES-1];
    assign miso_sync = miso_ff[SYNC_STAGES-1];

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ss_n_ff   <= '1;
            sclk_ff   <= '0;
            mosi_ff   <= '0;
            miso_ff   <= '0;
            sclk_prev <= 1'b0;
        end else begin
            ss_n_ff   <= {ss_n_ff[SYNC_STAGES-2:0], bus.ss_n};
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], bus.sclk};
            mosi_ff   <= {mosi_ff[SYNC_STAGES-2:0], bus.mosi};
            miso_ff   <= {miso_ff[SYNC_STAGES-2:0], bus.miso};
            sclk_prev <= sclk_sync;
        end
    end

    logic                 sclk_rise;
    logic                 ss_n_fall;
    logic                 word_done;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_SIZE-1:0] mosi_sh;
    logic [DATA_SIZE-1:0] miso_sh;
    logic [DATA_SIZE-1:0] mosi_next;
    logic [DATA_SIZE-1:0] miso_next;

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign ss_n_fall = ss_n_prev & ~ss_n_sync;
    // Gating on ss_n_sync means a deselect arriving with the final SCLK edge discards the word.
    assign word_done = ~ss_n_sync & sclk_rise & (bit_cnt == LAST_BIT);
    assign mosi_next = {mosi_sh[DATA_SIZE-2:0], mosi_sync};
    assign miso_next = {miso_sh[DATA_SIZE-2:0], miso_sync};

    hs_state_t            hs_state;
    logic [DATA_SIZE-1:0] mosi_q;
    logic [DATA_SIZE-1:0] miso_q;
    logic                 eval_q;
    logic                 busy_q;
    logic                 overrun_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ss_n_prev <= 1'b1;
            bit_cnt   <= '0;
            mosi_sh   <= '0;
            miso_sh   <= '0;
            hs_state  <= HS_READY;
            mosi_q    <= '0;
            miso_q    <= '0;
            eval_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ss_n_prev <= ss_n_sync;
            eval_q    <= 1'b0;

            // Shifter runs regardless of the handshake state.
            if (ss_n_sync) begin
                bit_cnt <= '0;
                mosi_sh <= '0;
                miso_sh <= '0;
            end else if (sclk_rise) begin
                mosi_sh <= mosi_next;
                miso_sh <= miso_next;
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (ss_n_fall) begin
                overrun_q <= 1'b0;
            end

            // Decisions use the current state only, so a word landing on the
            // ACK_HIGH -> READY edge is still an overrun.
            if (word_done && hs_state != HS_READY) begin
                overrun_q <= 1'b1;
            end

            case (hs_state)
                HS_READY: begin
                    if (word_done) begin
                        mosi_q   <= mosi_next;
                        miso_q   <= miso_next;
                        eval_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        hs_state <= HS_ACK_LOW;
                    end
                end
                HS_ACK_LOW: begin
                    // done_sig still high straight after eval is the old level; just keep waiting.
                    if (!bus.done_sig) begin
                        hs_state <= HS_ACK_HIGH;
                    end
                end
                HS_ACK_HIGH: begin
                    if (bus.done_sig) begin
                        hs_state <= HS_READY;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    hs_state <= HS_READY;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.real_mosi_data = mosi_q;
    assign bus.real_miso_data = miso_q;
    assign bus.eval           = eval_q;
    assign bus.busy           = busy_q;
    assign bus.frame_active   = ~ss_n_sync;
    assign bus.overrun_err    = overrun_q;
endmodule

// File: tb/tb_spi_byte_capture.sv
// Purpose : directed self-checking bench for spi_byte_capture (SYNC_STAGES=2, SCLK half-period 4 sys_clk).
// Latency : eval expected 3 sys_clk cycles after each final raw SCLK rise.
// Backpressure: done_sig either follows a logic-block model (drop 1 cycle after eval, rise 1 cycle later) or is held.
module tb_spi_byte_capture;
    localparam int DS   = 8;
    localparam int HALF = 4;

    logic sys_clk = 1'b0;
    logic rst;

    spi_byte_capture_if #(.DATA_SIZE(DS)) bus ();

    spi_byte_capture #(.DATA_SIZE(DS), .SYNC_STAGES(2)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int eval_cnt = 0;
    int eval_cyc = 0;
    int rise_cyc = 0;
    logic [7:0] cap_mosi [16];
    logic [7:0] cap_miso [16];

    logic done_auto  = 1'b0;
    logic done_level = 1'b1;
    logic done_model = 1'b1;
    logic drop_pend  = 1'b0;
    logic rise_pend  = 1'b0;

    always @(posedge sys_clk) cyc++;

    // Eval recorder and downstream done_sig model, both evaluated mid-cycle.
    always @(negedge sys_clk) begin
        if (bus.eval === 1'b1) begin
            if (eval_cnt < 16) begin
                cap_mosi[eval_cnt] = bus.real_mosi_data;
                cap_miso[eval_cnt] = bus.real_miso_data;
            end
            eval_cyc = cyc;
            eval_cnt++;
        end
        if (rise_pend) begin
            done_model = 1'b1;
            rise_pend  = 1'b0;
        end
        if (drop_pend) begin
            done_model = 1'b0;
            drop_pend  = 1'b0;
            rise_pend  = 1'b1;
        end
        if (bus.eval === 1'b1) drop_pend = 1'b1;
        bus.done_sig = done_auto ? done_model : done_level;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Mode 0: data changes with SCLK low, sampled on the rise. Sends bits hi down to lo.
    task automatic send_bits(input logic [7:0] mo, input logic [7:0] mi, input int hi, input int lo);
        for (int b = hi; b >= lo; b--) begin
            bus.mosi = mo[b];
            bus.miso = mi[b];
            bus.sclk = 1'b0;
            wait_cyc(HALF);
            bus.sclk = 1'b1;
            rise_cyc = cyc;
            wait_cyc(HALF);
        end
    endtask

    task automatic frame_start();
        bus.ss_n = 1'b0;
        wait_cyc(4);
    endtask

    task automatic frame_end();
        wait_cyc(2);
        bus.ss_n = 1'b1;
        bus.sclk = 1'b0;
        wait_cyc(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ss_n = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.miso = 1'b0;
        done_auto  = 1'b0;
        done_level = 1'b1;
        wait_cyc(3);
        n_cmp++; if (bus.real_mosi_data !== 8'h00) begin n_bad++; $display("FAIL reset_mosi: got %0h want 00", bus.real_mosi_data); end
        n_cmp++; if (bus.real_miso_data !== 8'h00) begin n_bad++; $display("FAIL reset_miso: got %0h want 00", bus.real_miso_data); end
        n_cmp++; if (bus.eval !== 1'b0) begin n_bad++; $display("FAIL reset_eval: got %b want 0", bus.eval); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_active !== 1'b0) begin n_bad++; $display("FAIL reset_frame_active: got %b want 0", bus.frame_active); end
        n_cmp++; if (bus.overrun_err !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", bus.overrun_err); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            done_level = i[0];
            wait_cyc(2);
        end
        done_level = 1'b1;
        wait_cyc(2);
        n_cmp++; if (eval_cnt !== 0) begin n_bad++; $display("FAIL idle_eval_count: got %0d want 0", eval_cnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.real_mosi_data !== 8'h00) begin n_bad++; $display("FAIL idle_mosi: got %0h want 00", bus.real_mosi_data); end
    endtask

    task automatic test_single_byte();
        int base;
        done_auto = 1'b1;
        base = eval_cnt;
        frame_start();
        n_cmp++; if (bus.frame_active !== 1'b1) begin n_bad++; $display("FAIL single_frame_active: got %b want 1", bus.frame_active); end
        send_bits(8'hA5, 8'h3C, 7, 0);
        frame_end();
        n_cmp++; if (eval_cnt - base !== 1) begin n_bad++; $display("FAIL single_eval_count: got %0d want 1", eval_cnt - base); end
        n_cmp++; if (cap_mosi[base] !== 8'hA5) begin n_bad++; $display("FAIL single_mosi: got %0h want a5", cap_mosi[base]); end
        n_cmp++; if (cap_miso[base] !== 8'h3C) begin n_bad++; $display("FAIL single_miso: got %0h want 3c", cap_miso[base]); end
        n_cmp++; if (eval_cyc - rise_cyc !== 3) begin n_bad++; $display("FAIL single_latency: got %0d want 3", eval_cyc - rise_cyc); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
        n_cmp++; if (bus.overrun_err !== 1'b0) begin n_bad++; $display("FAIL single_overrun: got %b want 0", bus.overrun_err); end
        n_cmp++; if (bus.frame_active !== 1'b0) begin n_bad++; $display("FAIL single_frame_idle: got %b want 0", bus.frame_active); end
        n_cmp++; if (bus.real_mosi_data !== 8'hA5) begin n_bad++; $display("FAIL single_hold: got %0h want a5", bus.real_mosi_data); end
    endtask

    task automatic test_back_to_back();
        int base;
        done_auto = 1'b1;
        base = eval_cnt;
        frame_start();
        send_bits(8'h01, 8'h80, 7, 0);
        send_bits(8'hFE, 8'h7F, 7, 0);
        frame_end();
        n_cmp++; if (eval_cnt - base !== 2) begin n_bad++; $display("FAIL b2b_eval_count: got %0d want 2", eval_cnt - base); end
        n_cmp++; if (cap_mosi[base] !== 8'h01) begin n_bad++; $display("FAIL b2b_mosi0: got %0h want 01", cap_mosi[base]); end
        n_cmp++; if (cap_miso[base] !== 8'h80) begin n_bad++; $display("FAIL b2b_miso0: got %0h want 80", cap_miso[base]); end
        n_cmp++; if (cap_mosi[base+1] !== 8'hFE) begin n_bad++; $display("FAIL b2b_mosi1: got %0h want fe", cap_mosi[base+1]); end
        n_cmp++; if (cap_miso[base+1] !== 8'h7F) begin n_bad++; $display("FAIL b2b_miso1: got %0h want 7f", cap_miso[base+1]); end
        n_cmp++; if (bus.overrun_err !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun_err); end
    endtask

    task automatic test_overrun();
        int base;
        done_auto  = 1'b0;
        done_level = 1'b0;
        wait_cyc(2);
        base = eval_cnt;
        frame_start();
        send_bits(8'h01, 8'h55, 7, 0);
        send_bits(8'hFE, 8'hAA, 7, 1);
        n_cmp++; if (bus.overrun_err !== 1'b0) begin n_bad++; $display("FAIL ovr_before_16th: got %b want 0", bus.overrun_err); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL ovr_busy: got %b want 1", bus.busy); end
        send_bits(8'hFE, 8'hAA, 0, 0);
        n_cmp++; if (bus.overrun_err !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", bus.overrun_err); end
        n_cmp++; if (eval_cnt - base !== 1) begin n_bad++; $display("FAIL ovr_eval_count: got %0d want 1", eval_cnt - base); end
        n_cmp++; if (bus.real_mosi_data !== 8'h01) begin n_bad++; $display("FAIL ovr_mosi_held: got %0h want 01", bus.real_mosi_data); end
        n_cmp++; if (bus.real_miso_data !== 8'h55) begin n_bad++; $display("FAIL ovr_miso_held: got %0h want 55", bus.real_miso_data); end
        done_level = 1'b1;
        wait_cyc(4);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ovr_release_busy: got %b want 0", bus.busy); end
        frame_end();
        n_cmp++; if (bus.overrun_err !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun_err); end
        frame_start();
        n_cmp++; if (bus.overrun_err !== 1'b0) begin n_bad++; $display("FAIL ovr_clear_on_ss: got %b want 0", bus.overrun_err); end
        frame_end();
        done_auto = 1'b1;
    endtask

    task automatic test_abort();
        int base;
        done_auto = 1'b1;
        base = eval_cnt;
        frame_start();
        send_bits(8'hFF, 8'hFF, 7, 3);
        frame_end();
        n_cmp++; if (eval_cnt !== base) begin n_bad++; $display("FAIL abort_no_eval: got %0d want %0d", eval_cnt, base); end
        frame_start();
        send_bits(8'h81, 8'h42, 7, 0);
        frame_end();
        n_cmp++; if (eval_cnt - base !== 1) begin n_bad++; $display("FAIL abort_eval_count: got %0d want 1", eval_cnt - base); end
        n_cmp++; if (cap_mosi[base] !== 8'h81) begin n_bad++; $display("FAIL abort_mosi: got %0h want 81", cap_mosi[base]); end
        n_cmp++; if (cap_miso[base] !== 8'h42) begin n_bad++; $display("FAIL abort_miso: got %0h want 42", cap_miso[base]); end
    endtask

    task automatic test_reset_mid_handshake();
        int base;
        done_auto  = 1'b0;
        done_level = 1'b1;
        wait_cyc(2);
        base = eval_cnt;
        frame_start();
        send_bits(8'h5A, 8'hC3, 7, 0);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
        send_bits(8'hFF, 8'hFF, 7, 5);
        rst = 1'b1;
        bus.sclk = 1'b0;
        #1;
        n_cmp++; if (bus.real_mosi_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_mosi: got %0h want 00", bus.real_mosi_data); end
        n_cmp++; if (bus.real_miso_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_miso: got %0h want 00", bus.real_miso_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_active !== 1'b0) begin n_bad++; $display("FAIL rstmid_frame_active: got %b want 0", bus.frame_active); end
        wait_cyc(3);
        rst = 1'b0;
        bus.ss_n = 1'b1;
        wait_cyc(4);
        done_auto = 1'b1;
        frame_start();
        send_bits(8'hC3, 8'h18, 7, 0);
        frame_end();
        n_cmp++; if (eval_cnt - base !== 2) begin n_bad++; $display("FAIL rstmid_eval_count: got %0d want 2", eval_cnt - base); end
        n_cmp++; if (cap_mosi[base+1] !== 8'hC3) begin n_bad++; $display("FAIL rstmid_mosi_after: got %0h want c3", cap_mosi[base+1]); end
        n_cmp++; if (cap_miso[base+1] !== 8'h18) begin n_bad++; $display("FAIL rstmid_miso_after: got %0h want 18", cap_miso[base+1]); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after: got %b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_byte_capture.md
Name: spi_byte_capture

Overview:
Upstream stage of the MITM logic block. It samples the raw SPI bus (SS_N, SCLK, MOSI, MISO) in the sys_clk domain and deserialises each full MOSI/MISO byte pair. It presents each pair on real_mosi_data/real_miso_data and pulses eval. It then holds off further evaluations until the logic block completes its done_sig handshake. SPI mode 0 only: sample on SCLK rising edge, MSB first.

Parameters:
DATA_SIZE, 8, bits per SPI word; width of both data outputs.
SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range is 2 or more.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous active-high reset.
ss_n  input  1  raw SPI slave select, active low, asynchronous to sys_clk.
sclk  input  1  raw SPI clock, asynchronous.
mosi  input  1  raw MOSI line, asynchronous.
miso  input  1  raw MISO line, asynchronous.
done_sig  input  1  done level from the downstream MITM logic block.
real_mosi_data  output  DATA_SIZE  last complete MOSI word.
real_miso_data  output  DATA_SIZE  last complete MISO word.
eval  output  1  one-cycle pulse: a new word pair is valid.
busy  output  1  high while waiting for the downstream handshake.
frame_active  output  1  synchronised SS_N is low.
overrun_err  output  1  sticky flag: a word completed while busy.

Behaviour:
- Reset, asynchronous, any cycle:
  - Synchroniser flops: ss_n chain to 1; sclk, mosi and miso chains to 0; previous-sclk register to 0.
  - Internal: shift registers 0, bit counter 0, handshake FSM to HS_READY.
  - Outputs: real_mosi_data 0, real_miso_data 0, eval 0, busy 0, frame_active 0, overrun_err 0.
  - Reset mid-byte discards all partial bits.
- Synchronisation: each raw input passes through SYNC_STAGES flops. sclk_rise = sclk_sync & ~sclk_prev.
- Supported SCLK rate: high and low phases each at least SYNC_STAGES+1 sys_clk periods. Faster SCLK is unsupported and its behaviour is unspecified.
- frame_active equals ~ss_n_sync.
- Shifter, runs independently of the handshake:
  - While ss_n_sync = 1: bit counter held at 0 and shift registers cleared. A frame abort therefore drops partial bits and produces no eval.
  - On ss_n_sync falling (1 to 0): overrun_err cleared.
  - While ss_n_sync = 0, on sclk_rise: shift mosi_sync and miso_sync into the LSB end, MSB first, and increment the counter.
  - When the counter reaches DATA_SIZE it wraps to 0, so back-to-back words in one frame are supported.
- Word completion (the sclk_rise carrying bit DATA_SIZE-1):
  - In HS_READY: load both outputs with the completed words in the same edge, assert eval for exactly one cycle, and go to HS_ACK_LOW.
  - In any other handshake state: outputs unchanged, no eval, overrun_err set to 1, and the word is dropped.
- Latency: eval and the new data are visible in the cycle after sys_clk edge SYNC_STAGES+1, counted from the first edge that samples the raw SCLK rise.
- Handshake FSM, encoded in 2 bits:
  - HS_READY: busy = 0. Leaves only on word completion.
  - HS_ACK_LOW: busy = 1. Waits for done_sig = 0, i.e. the logic block has accepted eval. done_sig = 1 on the first cycle after eval is expected and ignored.
  - HS_ACK_HIGH: busy = 1. Waits for done_sig = 1, then returns to HS_READY on the next edge.
  - Unused encoding: go to HS_READY with eval = 0.
  - The handshake is not aborted by ss_n rising. A pending evaluation always completes.
- Simultaneous events:
  - Word completion in the same cycle as the HS_ACK_HIGH to HS_READY transition counts as overrun. The FSM decides on its current state.
  - ss_n_sync rising in the same cycle as a completing sclk_rise: ss_n wins and the word is discarded.
- Data outputs hold their value between evals and are never cleared by ss_n.

Test Plan:
- Reset then idle, SYNC_STAGES=2, ss_n=1 -> all outputs 0, busy 0; done_sig toggling has no effect.
- Frame with MOSI 0xA5 / MISO 0x3C, SCLK half-period 4 sys_clk, done_sig modelled as in the logic block (drops 1 cycle after eval, rises 1 cycle later) -> exactly one eval pulse; real_mosi_data=0xA5 and real_miso_data=0x3C on that cycle; eval 3 cycles after the last raw SCLK rise; busy then returns to 0; overrun_err 0.
- Two back-to-back words in one frame, 0x01 then 0xFE, logic responding quickly -> two eval pulses with 0x01 then 0xFE; no overrun.
- Same two words with done_sig held 0 by the bench -> a single eval with 0x01; overrun_err=1 at the 16th bit; outputs stay 0x01; the next ss_n fall clears overrun_err.
- Abort: ss_n rises after 5 bits, then a new frame sends 0x81 -> no eval for the partial word; the next eval carries 0x81.
- rst asserted after eval while in HS_ACK_LOW, mid-next-byte -> outputs immediately 0, busy 0; the following full byte evaluates normally.
